// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings and default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/full_adder_df.sv
// One-bit dataflow full adder; the only arithmetic element in the serial adder datapath.
module full_adder_df (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial unsigned adder: one bit per clock through full_adder_df, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_cat;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_carry;

    full_adder_df u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // The newest sum bit enters at the MSB; once the last bit arrives this is the full result.
    assign res_cat = {fa_sum, res_sr};

    assign busy = (state == S_ADD);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath shift registers are reset too, so an aborted add leaves no stale bits behind.
        if (!rst_n) begin
            state   <= S_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        state   <= S_ADD;
                    end
                end
                S_ADD: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    res_sr  <= res_cat[WIDTH-1:1];
                    carry_q <= fa_carry;
                    if (cnt == CNT_LAST) begin
                        sum   <= res_cat;
                        cout  <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_q is the carry into the MSB during the final bit.
                        ovf   <= carry_q ^ fa_carry;
`endif
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
